// File: rtl/aclk_pkg.sv
// Shared constants for the alarm-clock sequencer: FSM state encoding,
// BCD digit width, default timing parameters and a saturating counter helper.
package aclk_pkg;

    // FSM state encoding (kept as plain constants for legacy tool flows)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZE  = 2'd2;

    // Width of one BCD digit of the time display
    localparam int BCD_W = 4;

    // Default behaviour of the sequencer
    localparam int SNOOZE_MIN_DEF       = 5;
    localparam int RING_TIMEOUT_SEC_DEF = 60;
    localparam int MAX_SNOOZE_DEF       = 3;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decrement that sticks at zero instead of wrapping
    function automatic logic [3:0] sat_dec4(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

endpackage

// File: rtl/aclk_alarm_match.sv
// Registered comparison of the current time against the alarm time.
// Produces a one-cycle trig on the first cycle the match is seen, so one
// matching minute can only start the alarm once.
module aclk_alarm_match
    import aclk_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alarm_on,
    input  logic [4*BCD_W-1:0]   cur_time,
    input  logic [4*BCD_W-1:0]   alm_time,
    output logic                 trig
);

    // match_r_q: times equal (registered); match_d_q: match_r_q one clock later
    logic match_r_q, match_r_d;
    logic match_d_q, match_d_d;

    // Next-state of the comparator pipeline
    always_comb begin
        match_r_d = (cur_time == alm_time);
        match_d_d = match_r_q;
    end

    // Comparator pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_r_q <= 1'b0;
            match_d_q <= 1'b0;
        end else begin
            match_r_q <= match_r_d;
            match_d_q <= match_d_d;
        end
    end

    assign trig = match_r_q & ~match_d_q & alarm_on;

endmodule

// File: rtl/aclk_alarm_sequencer.sv
// Alarm sequencer: rings when the alarm time is reached, handles snooze,
// dismiss and ring timeout, and drives the buzzer.
// Build option: define ACLK_BEEP_PATTERN_EN to make the buzzer beep
// 1 s on / 1 s off while ringing instead of sounding continuously.
module aclk_alarm_sequencer
    import aclk_pkg::*;
#(
    parameter int SNOOZE_MIN       = SNOOZE_MIN_DEF,
    parameter int RING_TIMEOUT_SEC = RING_TIMEOUT_SEC_DEF,
    parameter int MAX_SNOOZE       = MAX_SNOOZE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             one_second,
    input  logic             one_minute,
    input  logic             alarm_on,
    input  logic             snooze_button,
    input  logic             stop_button,
    input  logic [BCD_W-1:0] current_time_ms_hr,
    input  logic [BCD_W-1:0] current_time_ls_hr,
    input  logic [BCD_W-1:0] current_time_ms_min,
    input  logic [BCD_W-1:0] current_time_ls_min,
    input  logic [BCD_W-1:0] alarm_time_ms_hr,
    input  logic [BCD_W-1:0] alarm_time_ls_hr,
    input  logic [BCD_W-1:0] alarm_time_ms_min,
    input  logic [BCD_W-1:0] alarm_time_ls_min,
    output logic             sound_alarm,
    output logic             snooze_active,
    output logic [2:0]       snooze_left,
    output logic             alarm_missed
);

    localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_SEC - 1);
    localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MIN);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

    logic       trig;
    logic [1:0] state_q, state_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [3:0] snooze_cnt_q, snooze_cnt_d;
    logic [2:0] snooze_left_q, snooze_left_d;
    logic       alarm_missed_q, alarm_missed_d;
    logic       sound_alarm_q, sound_alarm_d;
    logic       snooze_active_q, snooze_active_d;
    logic       stop_btn_q, stop_btn_d;
    logic       snooze_btn_q, snooze_btn_d;
    logic       stop_edge, snooze_edge;

    aclk_alarm_match u_match (
        .clk      (clk),
        .reset    (reset),
        .alarm_on (alarm_on),
        .cur_time ({current_time_ms_hr, current_time_ls_hr,
                    current_time_ms_min, current_time_ls_min}),
        .alm_time ({alarm_time_ms_hr, alarm_time_ls_hr,
                    alarm_time_ms_min, alarm_time_ls_min}),
        .trig     (trig)
    );

    // Button edge detection: a held button acts only on its first cycle
    always_comb begin
        stop_btn_d   = stop_button;
        snooze_btn_d = snooze_button;
        stop_edge    = stop_button & ~stop_btn_q;
        snooze_edge  = snooze_button & ~snooze_btn_q;
    end

    // Ring/snooze state machine; priority: alarm_on low > stop > snooze > timeout/expiry > trig
    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snooze_cnt_d   = snooze_cnt_q;
        snooze_left_d  = snooze_left_q;
        alarm_missed_d = alarm_missed_q;
        if (!alarm_on) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stop_edge) begin
                        alarm_missed_d = 1'b0;
                    end else if (trig) begin
                        state_d        = ST_RINGING;
                        ring_cnt_d     = 8'd0;
                        snooze_left_d  = SNOOZE_MAX;
                        alarm_missed_d = 1'b0;
                    end
                end
                ST_RINGING: begin
                    if (one_second) begin
                        ring_cnt_d = sat_inc8(ring_cnt_q);
                    end
                    if (stop_edge) begin
                        state_d = ST_IDLE;
                    end else if (snooze_edge && (snooze_left_q != 3'd0)) begin
                        state_d       = ST_SNOOZE;
                        snooze_cnt_d  = SNOOZE_LOAD;
                        snooze_left_d = snooze_left_q - 3'd1;
                    end else if (one_second && (ring_cnt_q == RING_LAST)) begin
                        state_d        = ST_IDLE;
                        alarm_missed_d = 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_edge) begin
                        state_d = ST_IDLE;
                    end else if (one_minute) begin
                        snooze_cnt_d = sat_dec4(snooze_cnt_q);
                        if (snooze_cnt_q == 4'd1) begin
                            state_d    = ST_RINGING;
                            ring_cnt_d = 8'd0;
                        end
                    end else if (trig) begin
                        // A fresh alarm event during snooze restarts ringing with a full snooze budget
                        state_d       = ST_RINGING;
                        ring_cnt_d    = 8'd0;
                        snooze_left_d = SNOOZE_MAX;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Registered output decode from the next state
    always_comb begin
        snooze_active_d = (state_d == ST_SNOOZE);
        sound_alarm_d   = 1'b0;
        if (state_d == ST_RINGING) begin
`ifdef ACLK_BEEP_PATTERN_EN
            if (state_q != ST_RINGING) begin
                sound_alarm_d = 1'b1;
            end else if (one_second) begin
                sound_alarm_d = ~sound_alarm_q;
            end else begin
                sound_alarm_d = sound_alarm_q;
            end
`else
            sound_alarm_d = 1'b1;
`endif
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            ring_cnt_q      <= 8'd0;
            snooze_cnt_q    <= 4'd0;
            snooze_left_q   <= SNOOZE_MAX;
            alarm_missed_q  <= 1'b0;
            sound_alarm_q   <= 1'b0;
            snooze_active_q <= 1'b0;
            stop_btn_q      <= 1'b0;
            snooze_btn_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            ring_cnt_q      <= ring_cnt_d;
            snooze_cnt_q    <= snooze_cnt_d;
            snooze_left_q   <= snooze_left_d;
            alarm_missed_q  <= alarm_missed_d;
            sound_alarm_q   <= sound_alarm_d;
            snooze_active_q <= snooze_active_d;
            stop_btn_q      <= stop_btn_d;
            snooze_btn_q    <= snooze_btn_d;
        end
    end

    assign sound_alarm   = sound_alarm_q;
    assign snooze_active = snooze_active_q;
    assign snooze_left   = snooze_left_q;
    assign alarm_missed  = alarm_missed_q;

endmodule

// File: tb/tb_aclk_alarm_sequencer.sv
// Scoreboard bench for aclk_alarm_sequencer: a behavioural model predicts the
// outputs after each clock, a monitor compares them one clock later.
module tb_aclk_alarm_sequencer;

    localparam int SNOOZE_MIN       = 5;
    localparam int RING_TIMEOUT_SEC = 60;
    localparam int MAX_SNOOZE       = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0, one_minute = 1'b0, alarm_on = 1'b0;
    logic       snooze_button = 1'b0, stop_button = 1'b0;
    logic [3:0] cur_mh = 4'd0, cur_lh = 4'd0, cur_mm = 4'd0, cur_lm = 4'd0;
    logic [3:0] alm_mh = 4'd0, alm_lh = 4'd0, alm_mm = 4'd0, alm_lm = 4'd0;
    logic       sound_alarm, snooze_active, alarm_missed;
    logic [2:0] snooze_left;

    always #5 clk = ~clk;

    aclk_alarm_sequencer #(
        .SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk), .reset(reset), .one_second(one_second), .one_minute(one_minute),
        .alarm_on(alarm_on), .snooze_button(snooze_button), .stop_button(stop_button),
        .current_time_ms_hr(cur_mh), .current_time_ls_hr(cur_lh),
        .current_time_ms_min(cur_mm), .current_time_ls_min(cur_lm),
        .alarm_time_ms_hr(alm_mh), .alarm_time_ls_hr(alm_lh),
        .alarm_time_ms_min(alm_mm), .alarm_time_ls_min(alm_lm),
        .sound_alarm(sound_alarm), .snooze_active(snooze_active),
        .snooze_left(snooze_left), .alarm_missed(alarm_missed)
    );

    typedef struct packed {
        logic       sound;
        logic       snz_act;
        logic [2:0] left;
        logic       missed;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn = 0;

    // Behavioural model of one alarm event, in terms of the user-visible rules
    bit m_ringing, m_snoozing, m_missed, m_beep;
    int m_rung_secs, m_mins_to_wake, m_left;
    bit m_eq_prev, m_eq_prev2, m_stop_prev, m_snz_prev;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ringing = 0; m_snoozing = 0; m_missed = 0; m_beep = 0;
        m_rung_secs = 0; m_mins_to_wake = 0; m_left = MAX_SNOOZE;
        m_eq_prev = 0; m_eq_prev2 = 0; m_stop_prev = 0; m_snz_prev = 0;
    endtask

    task automatic start_ringing();
        m_ringing = 1; m_snoozing = 0; m_rung_secs = 0;
    endtask

    // Predict outputs after the coming clock edge from the inputs now applied
    task automatic model_step(output exp_t e);
        bit stop_e, snz_e, trig, was_ringing;
        stop_e = stop_button && !m_stop_prev;
        snz_e  = snooze_button && !m_snz_prev;
        // time matched during the previous cycle but not the one before it
        trig   = m_eq_prev && !m_eq_prev2 && alarm_on;
        was_ringing = m_ringing;
        if (!alarm_on) begin
            m_ringing = 0; m_snoozing = 0;
        end else if (m_ringing) begin
            if (stop_e) m_ringing = 0;
            else if (snz_e && m_left > 0) begin
                m_ringing = 0; m_snoozing = 1; m_mins_to_wake = SNOOZE_MIN; m_left--;
            end else if (one_second && m_rung_secs == RING_TIMEOUT_SEC - 1) begin
                m_ringing = 0; m_missed = 1;
            end else if (one_second && m_rung_secs < 255) m_rung_secs++;
        end else if (m_snoozing) begin
            if (stop_e) m_snoozing = 0;
            else if (one_minute) begin
                if (m_mins_to_wake == 1) start_ringing();
                else if (m_mins_to_wake > 0) m_mins_to_wake--;
            end else if (trig) begin
                start_ringing(); m_left = MAX_SNOOZE;
            end
        end else begin
            if (stop_e) m_missed = 0;
            else if (trig) begin
                start_ringing(); m_left = MAX_SNOOZE; m_missed = 0;
            end
        end
        if (!m_ringing) m_beep = 0;
        else if (!was_ringing) m_beep = 1;
        else if (one_second) m_beep = !m_beep;
        m_eq_prev2  = m_eq_prev;
        m_eq_prev   = ({cur_mh, cur_lh, cur_mm, cur_lm} == {alm_mh, alm_lh, alm_mm, alm_lm});
        m_stop_prev = stop_button;
        m_snz_prev  = snooze_button;
`ifdef ACLK_BEEP_PATTERN_EN
        e.sound = m_beep;
`else
        e.sound = m_ringing;
`endif
        e.snz_act = m_snoozing;
        e.left    = 3'(m_left);
        e.missed  = m_missed;
    endtask

    // Called at a falling edge with inputs set; ends at the next falling edge
    task automatic step();
        exp_t e;
        model_step(e);
        exp_q.push_back(e);
        @(negedge clk);
        one_second = 1'b0;
        one_minute = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_cur(input int h, input int m);
        cur_mh = 4'(h / 10); cur_lh = 4'(h % 10);
        cur_mm = 4'(m / 10); cur_lm = 4'(m % 10);
    endtask

    task automatic sec_tick();
        one_second = 1'b1; step();
    endtask

    task automatic min_tick();
        one_minute = 1'b1; step();
    endtask

    task automatic press_stop();
        stop_button = 1'b1; step(); step(); stop_button = 1'b0; step();
    endtask

    task automatic press_snooze();
        snooze_button = 1'b1; step(); step(); snooze_button = 1'b0; step();
    endtask

    task automatic retrigger();
        set_cur(7, 31); step(); step();
        set_cur(7, 30); step(); step(); step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sound"}, 8'(sound_alarm), 8'd0);
        check({tag, "_snooze_active"}, 8'(snooze_active), 8'd0);
        check({tag, "_snooze_left"}, 8'(snooze_left), 8'(MAX_SNOOZE));
        check({tag, "_missed"}, 8'(alarm_missed), 8'd0);
    endtask

    // Monitor: one expected record per clock, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: sound=%0b snz=%0b left=%0d missed=%0b (exp %0b %0b %0d %0b)",
                         txn, sound_alarm, snooze_active, snooze_left, alarm_missed,
                         e.sound, e.snz_act, e.left, e.missed);
                check("sound_alarm", 8'(sound_alarm), 8'(e.sound));
                check("snooze_active", 8'(snooze_active), 8'(e.snz_act));
                check("snooze_left", 8'(snooze_left), 8'(e.left));
                check("alarm_missed", 8'(alarm_missed), 8'(e.missed));
            end
        end
    end

    initial begin
        // Power-on reset
        alm_mh = 4'd0; alm_lh = 4'd7; alm_mm = 4'd3; alm_lm = 4'd0;
        set_cur(7, 29);
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        model_reset();

        // Alarm at 07:30: ring, stop, no re-trigger in the same minute
        alarm_on = 1'b1;
        idle(3);
        set_cur(7, 30); idle(4);
        press_stop(); idle(5);

        // Three snoozes of five minutes each, then a fourth is refused
        retrigger();
        for (int k = 0; k < MAX_SNOOZE; k++) begin
            press_snooze(); idle(2);
            repeat (SNOOZE_MIN) begin min_tick(); idle(1); end
            idle(2);
        end
        press_snooze(); idle(2);

        // Ring timeout sets alarm_missed; stop in idle clears it
        repeat (RING_TIMEOUT_SEC) begin sec_tick(); idle(1); end
        idle(2);
        press_stop(); idle(2);

        // Stop and snooze together while ringing
        retrigger();
        stop_button = 1'b1; snooze_button = 1'b1; step();
        stop_button = 1'b0; snooze_button = 1'b0; idle(3);

        // alarm_on dropped during snooze
        retrigger();
        press_snooze(); idle(2);
        alarm_on = 1'b0; idle(2);
        alarm_on = 1'b1; idle(2);

        // Beep pattern / ringing seconds, then asynchronous reset mid-ring
        retrigger();
        repeat (4) begin sec_tick(); idle(1); end
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        set_cur(7, 29);
        repeat (2) @(negedge clk);
        check_reset_outputs("held_rst");
        reset = 1'b1;
        model_reset();
        idle(2);

        // Randomised traffic around the alarm minute
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) set_cur(7, 29 + int'($urandom_range(2)));
            alarm_on = ($urandom_range(63) != 0);
            if ($urandom_range(5) == 0) snooze_button = ~snooze_button;
            if ($urandom_range(7) == 0) stop_button = ~stop_button;
            one_second = ($urandom_range(2) == 0);
            one_minute = ($urandom_range(9) == 0);
            step();
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aclk_alarm_sequencer.md
Name: aclk_alarm_sequencer

Overview:
- Decides when the alarm sounds, snoozes, times out and is dismissed.
- Compares the running current time against the stored alarm time and drives sound_alarm through a ring/snooze state machine.
- Sits beside aclk_lcd_display and consumes the one_second/one_minute ticks from aclk_timegen. Once integrated, it is the single source of sound_alarm.

Parameters:
- SNOOZE_MIN, default 5: snooze length in minutes (1..15).
- RING_TIMEOUT_SEC, default 60: seconds of ringing before auto-silence (1..255).
- MAX_SNOOZE, default 3: snoozes allowed per alarm event (0..7).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- one_second  in  1  single-cycle tick, once per second
- one_minute  in  1  single-cycle tick, once per minute
- alarm_on  in  1  alarm enable switch (level)
- snooze_button  in  1  snooze request (level; rising edge acts)
- stop_button  in  1  dismiss request (level; rising edge acts)
- current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  in  4 each  BCD current time
- alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min  in  4 each  BCD alarm time
- sound_alarm  out  1  buzzer drive
- snooze_active  out  1  high while in SNOOZE
- snooze_left  out  3  remaining snoozes for the current event
- alarm_missed  out  1  sticky flag: an alarm timed out unanswered

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; all counters 0; button edge registers 0; match_r = 0, match_d = 0.
  - sound_alarm = 0, snooze_active = 0, snooze_left = MAX_SNOOZE, alarm_missed = 0.
  - Outputs are all registered.
- Match detection:
  - match_r <= (all four current digits == all four alarm digits); match_d <= match_r.
  - trig = match_r & ~match_d & alarm_on.
  - A given minute can trigger only once, so a stop inside the matching minute does not re-trigger.
  - Latency: current time update -> sound_alarm high = 2 clk.
- Buttons: rising edge detected internally (1 clk); a held level acts once.
- FSM states: IDLE, RINGING, SNOOZE.
- IDLE:
  - trig -> RINGING; ring_cnt = 0; snooze_left = MAX_SNOOZE; alarm_missed cleared.
  - Button edges in IDLE: stop clears alarm_missed; snooze is ignored.
- RINGING (sound_alarm = 1):
  - ring_cnt increments on one_second.
  - stop edge -> IDLE.
  - Else snooze edge with snooze_left > 0 -> SNOOZE; snooze_cnt = SNOOZE_MIN; snooze_left decrements.
  - Snooze edge with snooze_left == 0 is ignored.
  - Else ring_cnt == RING_TIMEOUT_SEC-1 on a one_second tick -> IDLE; alarm_missed = 1.
  - trig in RINGING is ignored.
- SNOOZE (snooze_active = 1, sound_alarm = 0):
  - snooze_cnt decrements on one_minute; on the tick where snooze_cnt == 1 -> RINGING with ring_cnt = 0.
  - stop edge -> IDLE.
  - trig -> RINGING; snooze_left reloads to MAX_SNOOZE.
- Priority within one cycle: alarm_on low > stop > snooze > timeout/expiry > trig.
- alarm_on low in any state -> IDLE on the next edge, sound_alarm 0; alarm_missed is unchanged.
- Counter widths: ring_cnt 8 bits, snooze_cnt 4 bits. Neither counter wraps; each is held at its terminal value.
- Time-set changes of current_time while in SNOOZE do not affect snooze_cnt.

Optional Feature:
- Macro: ACLK_BEEP_PATTERN_EN.
- Defined: in RINGING, sound_alarm toggles on every one_second tick, starting at 1 on entry (1 s on / 1 s off).
- Undefined: sound_alarm is a steady 1 throughout RINGING.
- The FSM and all timing are identical in both builds.

Decomposition:
- Package aclk_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RINGING=2'd1, ST_SNOOZE=2'd2;
  - BCD digit width constant (4);
  - default values for SNOOZE_MIN, RING_TIMEOUT_SEC, MAX_SNOOZE.
- Sub-module aclk_alarm_match: registered 16-bit BCD comparator plus match_r/match_d edge detect; outputs trig.

Test Plan:
- Alarm 07:30, alarm_on=1, current time steps 07:29->07:30 -> sound_alarm=1 exactly 2 clk later; stop edge -> 0 next clk; stays 0 for rest of minute 07:30.
- Ringing, snooze edge -> snooze_active=1, snooze_left=2, sound_alarm=0; 5 one_minute ticks -> RINGING on the 5th tick edge.
- Snooze 3 times (MAX_SNOOZE=3), then 4th snooze edge -> ignored, sound_alarm stays 1, snooze_left=0.
- Ringing with no input, 60 one_second ticks -> sound_alarm=0 after the 60th, alarm_missed=1; stop edge in IDLE clears it.
- Stop and snooze edges in the same cycle while RINGING -> IDLE; alarm_on dropped mid-SNOOZE -> IDLE next clk, snooze_active=0.
- Reset asserted mid-RINGING -> all outputs at reset values immediately, without waiting for a clk edge; with ACLK_BEEP_PATTERN_EN, sound_alarm follows the 1,0,1,0 pattern per one_second tick.
